// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, decoder branch-select encoding, sequencer states.
package cpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned BR_W  = 4;
    localparam int unsigned IMM_W = 16;
    localparam int unsigned JT_W  = 26;
    localparam int unsigned OP_W  = 6;

    // Primary opcodes seen by the decoder
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_BLEZ  = 6'h06;
    localparam logic [OP_W-1:0] OP_BGTZ  = 6'h07;

    // Branch-select codes produced by the decoder; 12-15 are reserved
    localparam logic [BR_W-1:0] BR_PC4  = 4'd0;
    localparam logic [BR_W-1:0] BR_J    = 4'd1;
    localparam logic [BR_W-1:0] BR_JR   = 4'd2;
    localparam logic [BR_W-1:0] BR_BEQ  = 4'd3;
    localparam logic [BR_W-1:0] BR_BNE  = 4'd4;
    localparam logic [BR_W-1:0] BR_BLEZ = 4'd5;
    localparam logic [BR_W-1:0] BR_BGTZ = 4'd6;
    localparam logic [BR_W-1:0] BR_BLT  = 4'd7;
    localparam logic [BR_W-1:0] BR_BGT  = 4'd8;
    localparam logic [BR_W-1:0] BR_BGE  = 4'd9;
    localparam logic [BR_W-1:0] BR_BLE  = 4'd10;
    localparam logic [BR_W-1:0] BR_JAL  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DECODE  = 2'd2,
        ST_RESOLVE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_branch_compare.sv
// Branch condition evaluation.
// Ports: branch (select code), rs_val/rt_val (operands);
//        cond_true (redirect to non-sequential target), is_reserved (codes 12-15).
module branch_compare
    import cpu_pkg::*;
(
    input  logic [BR_W-1:0] branch,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            cond_true,
    output logic            is_reserved
);

    logic signed [XLEN-1:0] rs_s;
    logic signed [XLEN-1:0] rt_s;

    assign rs_s = $signed(rs_val);
    assign rt_s = $signed(rt_val);

    // Unconditional jumps count as a true condition so callers see one redirect flag
    always_comb begin
        cond_true   = 1'b0;
        is_reserved = 1'b0;
        case (branch)
            BR_PC4:  cond_true = 1'b0;
            BR_J,
            BR_JR,
            BR_JAL:  cond_true = 1'b1;
            BR_BEQ:  cond_true = (rs_val == rt_val);
            BR_BNE:  cond_true = (rs_val != rt_val);
            BR_BLEZ: cond_true = (rs_s <= $signed(32'sd0));
            BR_BGTZ: cond_true = (rs_s >  $signed(32'sd0));
            BR_BLT:  cond_true = (rs_s <  rt_s);
            BR_BGT:  cond_true = (rs_s >  rt_s);
            BR_BGE:  cond_true = (rs_s >= rt_s);
            BR_BLE:  cond_true = (rs_s <= rt_s);
            default: is_reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer / instruction-fetch front end.
// Ports: clk, rst (sync, active-high); branch/imm/jtarget/rs_val/rt_val from decode and
//        register file; stall; imem_ready/imem_req/imem_addr fetch handshake;
//        ir_load, link_we/link_data, taken, illegal pulses; pc and retired counters.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BR_W-1:0]  branch,
    input  logic [IMM_W-1:0] imm,
    input  logic [JT_W-1:0]  jtarget,
    input  logic [XLEN-1:0]  rs_val,
    input  logic [XLEN-1:0]  rt_val,
    input  logic             stall,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    output logic             ir_load,
    output logic [XLEN-1:0]  pc,
    output logic             link_we,
    output logic [XLEN-1:0]  link_data,
    output logic             taken,
    output logic             illegal,
    output logic [XLEN-1:0]  retired
);

    seq_state_t      state;
    seq_state_t      state_next;
    logic            imem_req_next;
    logic            ir_load_next;
    logic            link_we_next;
    logic            taken_next;
    logic            illegal_next;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] retired_next;
    logic [XLEN-1:0] link_data_next;

    logic            cond_true;
    logic            is_reserved;
    logic [XLEN-1:0] p4;
    logic [XLEN-1:0] bt;
    logic [XLEN-1:0] target;

    branch_compare u_branch_compare (
        .branch      (branch),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .cond_true   (cond_true),
        .is_reserved (is_reserved)
    );

    assign imem_addr = pc;

    // Candidate targets; all arithmetic wraps mod 2^32
    assign p4 = pc + 32'd4;
    assign bt = p4 + {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};

    always_comb begin
        case (branch)
            BR_J, BR_JAL: target = {p4[XLEN-1:XLEN-4], jtarget, 2'b00};
            BR_JR:        target = {rs_val[XLEN-1:2], 2'b00};
            default:      target = bt;
        endcase
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_next     = state;
        imem_req_next  = 1'b0;
        ir_load_next   = 1'b0;
        link_we_next   = 1'b0;
        taken_next     = 1'b0;
        illegal_next   = 1'b0;
        pc_next        = pc;
        retired_next   = retired;
        link_data_next = link_data;
        case (state)
            ST_IDLE: begin
                state_next    = ST_FETCH;
                imem_req_next = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    state_next   = ST_DECODE;
                    ir_load_next = 1'b1;
                end else begin
                    imem_req_next = 1'b1;
                end
            end
            ST_DECODE: begin
                state_next = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                if (!stall) begin
                    state_next     = ST_FETCH;
                    imem_req_next  = 1'b1;
                    pc_next        = cond_true ? target : p4;
                    retired_next   = retired + 32'd1;
                    taken_next     = cond_true;
                    link_we_next   = (branch == BR_JAL);
                    illegal_next   = is_reserved;
                    // Captured so link_data still holds the pre-update pc+4 while link_we is high
                    link_data_next = p4;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            imem_req  <= 1'b0;
            ir_load   <= 1'b0;
            link_we   <= 1'b0;
            taken     <= 1'b0;
            illegal   <= 1'b0;
            pc        <= RESET_PC;
            retired   <= '0;
            link_data <= RESET_PC + 32'd4;
        end else begin
            state     <= state_next;
            imem_req  <= imem_req_next;
            ir_load   <= ir_load_next;
            link_we   <= link_we_next;
            taken     <= taken_next;
            illegal   <= illegal_next;
            pc        <= pc_next;
            retired   <= retired_next;
            link_data <= link_data_next;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [3:0]  branch;
    logic [15:0] imm;
    logic [25:0] jtarget;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ir_load;
    logic [31:0] pc;
    logic        link_we;
    logic [31:0] link_data;
    logic        taken;
    logic        illegal;
    logic [31:0] retired;

    int n_checks;
    int n_fail;
    int exp_ret;

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .branch     (branch),
        .imm        (imm),
        .jtarget    (jtarget),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .stall      (stall),
        .imem_ready (imem_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .ir_load    (ir_load),
        .pc         (pc),
        .link_we    (link_we),
        .link_data  (link_data),
        .taken      (taken),
        .illegal    (illegal),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) until the sequencer is in FETCH; called at a negedge
    task automatic wait_fetch();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_req) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) chk("fetch_wait", 32'd0, 32'd1);
    endtask

    // One zero-wait instruction; returns at the negedge after the RESOLVE edge
    task automatic do_instr(input logic [3:0] br, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [15:0] im, input logic [25:0] jt);
        wait_fetch();
        branch     = br;
        rs_val     = rs;
        rt_val     = rt;
        imm        = im;
        jtarget    = jt;
        stall      = 1'b0;
        imem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_ret++;
    endtask

    task automatic set_pc(input logic [31:0] target);
        do_instr(4'd2, target, 32'd0, 16'd0, 26'd0);
    endtask

    // Conditional branch from pc=0x1000 with imm=0x10: taken -> 0x1044, not taken -> 0x1004
    task automatic cond_case(input string tag, input logic [3:0] br, input logic [31:0] rs,
                             input logic [31:0] rt, input logic exp_tk);
        set_pc(32'h0000_1000);
        do_instr(br, rs, rt, 16'h0010, 26'd0);
        chk({tag, "_pc"}, pc, exp_tk ? 32'h0000_1044 : 32'h0000_1004);
        chk({tag, "_taken"}, 32'(taken), 32'(exp_tk));
    endtask

    initial begin
        logic [31:0] addrs [0:3];
        int          n_addr;
        int          n_taken;
        int          n_irload;

        n_checks   = 0;
        n_fail     = 0;
        exp_ret    = 0;
        rst        = 1'b1;
        branch     = 4'd0;
        imm        = 16'd0;
        jtarget    = 26'd0;
        rs_val     = 32'd0;
        rt_val     = 32'd0;
        stall      = 1'b0;
        imem_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_pulses", {28'd0, ir_load, link_we, taken, illegal}, 32'h0);

        // Sequential fetch with zero-wait memory
        rst      = 1'b0;
        n_addr   = 0;
        n_taken  = 0;
        n_irload = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (imem_req && n_addr < 4) begin
                addrs[n_addr] = imem_addr;
                n_addr++;
            end
            if (taken) n_taken++;
            if (ir_load) n_irload++;
        end
        chk("seq_naddr", 32'(n_addr), 32'd4);
        chk("seq_addr0", addrs[0], 32'h0);
        chk("seq_addr1", addrs[1], 32'h4);
        chk("seq_addr2", addrs[2], 32'h8);
        chk("seq_retired", retired, 32'd3);
        chk("seq_taken_cnt", 32'(n_taken), 32'd0);
        chk("seq_irload_cnt", 32'(n_irload), 32'd4);
        exp_ret = 3;

        // The RESOLVE in flight retires with branch=0 before the first directed instruction
        wait_fetch();
        exp_ret = 4;
        chk("seq_pc4", pc, 32'h10);

        // jr then taken beq with negative offset
        set_pc(32'h0000_0100);
        chk("jr_pc", pc, 32'h100);
        chk("jr_taken", 32'(taken), 32'd1);
        do_instr(4'd3, 32'd5, 32'd5, 16'hFFFE, 26'd0);
        chk("beq_t_pc", pc, 32'h0FC);
        chk("beq_t_taken", 32'(taken), 32'd1);
        chk("beq_t_link_we", 32'(link_we), 32'd0);

        // beq not taken
        set_pc(32'h0000_0100);
        do_instr(4'd3, 32'd5, 32'd6, 16'hFFFE, 26'd0);
        chk("beq_nt_pc", pc, 32'h104);
        chk("beq_nt_taken", 32'(taken), 32'd0);

        // Signed compares and single-operand branches
        cond_case("blt_neg", 4'd7, 32'hFFFF_FFFF, 32'd1, 1'b1);
        cond_case("bgt_neg", 4'd8, 32'hFFFF_FFFF, 32'd1, 1'b0);
        cond_case("bne", 4'd4, 32'd1, 32'd2, 1'b1);
        cond_case("bge_eq", 4'd9, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 1'b1);
        cond_case("ble_gt", 4'd10, 32'd3, 32'hFFFF_FFFF, 1'b0);
        cond_case("blez_zero", 4'd5, 32'd0, 32'd0, 1'b1);
        cond_case("bgtz_zero", 4'd6, 32'd0, 32'd0, 1'b0);
        cond_case("bgtz_min", 4'd6, 32'h8000_0000, 32'd0, 1'b0);

        // jal: link value is pre-update pc+4
        set_pc(32'h4000_0010);
        do_instr(4'd11, 32'd0, 32'd0, 16'd0, 26'h0000040);
        chk("jal_link_we", 32'(link_we), 32'd1);
        chk("jal_link_data", link_data, 32'h4000_0014);
        chk("jal_pc", pc, 32'h4000_0100);
        chk("jal_taken", 32'(taken), 32'd1);

        // jr held in RESOLVE by stall for 3 cycles
        wait_fetch();
        branch     = 4'd2;
        rs_val     = 32'h0000_0203;
        imem_ready = 1'b1;
        stall      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_pc", pc, 32'h4000_0100);
            chk("stall_taken", 32'(taken), 32'd0);
        end
        chk("stall_retired", retired, 32'(exp_ret));
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_ret++;
        chk("jr_after_stall_pc", pc, 32'h200);
        chk("jr_after_stall_taken", 32'(taken), 32'd1);
        chk("jr_after_stall_retired", retired, 32'(exp_ret));

        // Reserved code
        do_instr(4'd13, 32'd0, 32'd0, 16'd0, 26'd0);
        chk("rsv_pc", pc, 32'h204);
        chk("rsv_illegal", 32'(illegal), 32'd1);
        chk("rsv_taken", 32'(taken), 32'd0);
        chk("rsv_retired", retired, 32'(exp_ret));

        // PC wrap
        set_pc(32'hFFFF_FFFC);
        do_instr(4'd0, 32'd0, 32'd0, 16'd0, 26'd0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_taken", 32'(taken), 32'd0);
        chk("wrap_illegal", 32'(illegal), 32'd0);

        // Reset while a fetch is outstanding
        imem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midfetch_req_before", 32'(imem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midfetch_req_after", 32'(imem_req), 32'd0);
        chk("midfetch_pc", pc, 32'h0);
        chk("midfetch_retired", retired, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
